// File: rtl/sweep_pair_collector_pkg.sv
// Shared types for the sweep pair collector: widths, FSM encoding and the packed pair record.
package sweep_pair_pkg;

  localparam int DATA_W = 17;
  localparam int TS_W   = 24;

  localparam logic [0:0] ST_IDLE       = 1'b0;
  localparam logic [0:0] ST_HAVE_FIRST = 1'b1;

  typedef struct packed {
    logic [DATA_W-1:0] data_0;
    logic [DATA_W-1:0] data_1;
    logic [TS_W-1:0]   ts_0;
    logic [TS_W-1:0]   delta;
  } pair_t;

  // Timestamps wrap at 2^24, so distances are always taken modulo the width.
  function automatic logic [TS_W-1:0] ts_diff(input logic [TS_W-1:0] a, input logic [TS_W-1:0] b);
    return a - b;
  endfunction

endpackage

// File: rtl/sweep_pair_collector_if.sv
// Pair output bus: valid/ready handshake plus the head pair fields.
interface sweep_pair_collector_if;
  import sweep_pair_pkg::*;

  logic              pair_valid;
  logic              pair_ready;
  logic [DATA_W-1:0] pair_data_0;
  logic [DATA_W-1:0] pair_data_1;
  logic [TS_W-1:0]   pair_ts_0;
  logic [TS_W-1:0]   pair_delta;

  modport master (output pair_valid, pair_data_0, pair_data_1, pair_ts_0, pair_delta,
                  input  pair_ready);
  modport slave  (input  pair_valid, pair_data_0, pair_data_1, pair_ts_0, pair_delta,
                  output pair_ready);
endinterface

// File: rtl/sweep_pair_fifo.sv
// First-word-fall-through FIFO of pair records; a pop in the same cycle frees room for a push when full.
module sweep_pair_fifo
  import sweep_pair_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  pair_t                    pair_i,
  input  logic                     pop_i,
  output pair_t                    head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  pair_t         mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == FULL_CNT);
  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= pair_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

// File: rtl/sweep_pair_collector.sv
// Pairs consecutive decoded sweep words within MAX_GAP_TICKS and queues them for the solver.
// Define SWEEP_PAIR_STATS_EN to add saturating orphan_count / drop_count outputs.
module sweep_pair_collector
  import sweep_pair_pkg::*;
#(
  parameter int              FIFO_DEPTH    = 4,
  parameter logic [TS_W-1:0] MAX_GAP_TICKS = 24'd960000
) (
  input  logic                        clk_96MHz,
  input  logic                        reset,
  input  logic                        data_availible,
  input  logic [DATA_W-1:0]           decoded_data,
  input  logic [TS_W-1:0]             timestamp_last_data,
  input  logic [TS_W-1:0]             system_timestamp,
  sweep_pair_collector_if.master      pair_if,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow
`ifdef SWEEP_PAIR_STATS_EN
  ,
  output logic [15:0]                 orphan_count,
  output logic [15:0]                 drop_count
`endif
);
  logic [0:0]        state_q, state_d;
  logic [DATA_W-1:0] w0_q, w0_d;
  logic [TS_W-1:0]   t0_q, t0_d;
  logic [TS_W-1:0]   d;
  logic              pair_ok, timeout, push, pop, full, drop;
  logic              overflow_q;
  pair_t             new_pair, head;

  assign d       = ts_diff(timestamp_last_data, t0_q);
  assign pair_ok = (d != '0) && (d <= MAX_GAP_TICKS);
  assign timeout = ts_diff(system_timestamp, t0_q) > MAX_GAP_TICKS;
  assign pop     = pair_if.pair_valid && pair_if.pair_ready;
  assign drop    = push && full && !pop;

  assign new_pair = '{data_0: w0_q, data_1: decoded_data, ts_0: t0_q, delta: d};

  always_comb begin
    state_d = state_q;
    w0_d    = w0_q;
    t0_d    = t0_q;
    push    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (data_availible) begin
          w0_d    = decoded_data;
          t0_d    = timestamp_last_data;
          state_d = ST_HAVE_FIRST;
        end
      end
      default: begin
        // A pulse always wins over the timeout; only the delta decides pairing.
        if (data_availible) begin
          if (pair_ok) begin
            push    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            w0_d = decoded_data;
            t0_d = timestamp_last_data;
          end
        end else if (timeout) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk_96MHz or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      w0_q       <= '0;
      t0_q       <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      w0_q       <= w0_d;
      t0_q       <= t0_d;
      overflow_q <= overflow_q | drop;
    end
  end

  sweep_pair_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk_96MHz),
    .rst     (reset),
    .push_i  (push),
    .pair_i  (new_pair),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (fifo_count),
    .full_o  (full)
  );

  assign overflow            = overflow_q;
  assign pair_if.pair_valid  = (fifo_count != '0);
  assign pair_if.pair_data_0 = head.data_0;
  assign pair_if.pair_data_1 = head.data_1;
  assign pair_if.pair_ts_0   = head.ts_0;
  assign pair_if.pair_delta  = head.delta;

`ifdef SWEEP_PAIR_STATS_EN
  logic        orphan_ev;
  logic [15:0] orphan_q, drop_q;

  assign orphan_ev = (state_q == ST_HAVE_FIRST) && (data_availible ? !pair_ok : timeout);

  always_ff @(posedge clk_96MHz or posedge reset) begin
    if (reset) begin
      orphan_q <= '0;
      drop_q   <= '0;
    end else begin
      if (orphan_ev && orphan_q != 16'hFFFF) orphan_q <= orphan_q + 1'b1;
      if (drop && drop_q != 16'hFFFF)        drop_q   <= drop_q + 1'b1;
    end
  end

  assign orphan_count = orphan_q;
  assign drop_count   = drop_q;
`endif
endmodule

// File: tb/tb_sweep_pair_collector.sv
// Directed scenarios plus randomized pulses, checked every cycle against a queue-based pairing model.
module tb_sweep_pair_collector;
  import sweep_pair_pkg::*;

  localparam int              DEPTH = 4;
  localparam logic [TS_W-1:0] MAXG  = 24'd960000;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              dav = 1'b0;
  logic [DATA_W-1:0] ddata = '0;
  logic [TS_W-1:0]   dts = '0, sys = '0;
  logic [2:0]        fifo_count;
  logic              overflow;
`ifdef SWEEP_PAIR_STATS_EN
  logic [15:0]       orphan_count, drop_count;
`endif

  sweep_pair_collector_if pif();

  sweep_pair_collector #(.FIFO_DEPTH(DEPTH), .MAX_GAP_TICKS(MAXG)) dut (
    .clk_96MHz           (clk),
    .reset               (reset),
    .data_availible      (dav),
    .decoded_data        (ddata),
    .timestamp_last_data (dts),
    .system_timestamp    (sys),
    .pair_if             (pif),
    .fifo_count          (fifo_count),
    .overflow            (overflow)
`ifdef SWEEP_PAIR_STATS_EN
    ,
    .orphan_count        (orphan_count),
    .drop_count          (drop_count)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: "holding a first word" flag, the pending word, and a queue of pairs.
  pair_t             mq[$];
  bit                m_have;
  logic [DATA_W-1:0] m_w0;
  logic [TS_W-1:0]   m_t0;
  bit                m_ovf;
  int                m_orphan, m_drop;

  task automatic model_reset();
    mq.delete();
    m_have = 0; m_w0 = '0; m_t0 = '0; m_ovf = 0; m_orphan = 0; m_drop = 0;
  endtask

  task automatic model_step(input bit p, input logic [DATA_W-1:0] w, input logic [TS_W-1:0] ts,
                            input logic [TS_W-1:0] st, input bit rdy);
    bit             do_pop, do_push;
    pair_t          np;
    logic [TS_W-1:0] gap, age;
    do_pop  = (mq.size() != 0) && rdy;
    do_push = 0;
    np      = '0;
    gap     = ts - m_t0;
    age     = st - m_t0;
    if (m_have && p) begin
      if (gap >= 1 && gap <= MAXG) begin
        np = '{data_0: m_w0, data_1: w, ts_0: m_t0, delta: gap};
        do_push = 1;
        m_have  = 0;
      end else begin
        m_w0 = w; m_t0 = ts;
        if (m_orphan < 65535) m_orphan++;
      end
    end else if (m_have) begin
      if (age > MAXG) begin
        m_have = 0;
        if (m_orphan < 65535) m_orphan++;
      end
    end else if (p) begin
      m_have = 1; m_w0 = w; m_t0 = ts;
    end
    if (do_pop) void'(mq.pop_front());
    if (do_push) begin
      if (mq.size() < DEPTH) mq.push_back(np);
      else begin
        m_ovf = 1;
        if (m_drop < 65535) m_drop++;
      end
    end
  endtask

  task automatic check_outputs();
    chk("valid", {31'b0, pif.pair_valid}, {31'b0, mq.size() != 0});
    chk("count", {29'b0, fifo_count}, mq.size());
    chk("overflow", {31'b0, overflow}, {31'b0, m_ovf});
    if (mq.size() != 0) begin
      chk("data_0", {15'b0, pif.pair_data_0}, {15'b0, mq[0].data_0});
      chk("data_1", {15'b0, pif.pair_data_1}, {15'b0, mq[0].data_1});
      chk("ts_0", {8'b0, pif.pair_ts_0}, {8'b0, mq[0].ts_0});
      chk("delta", {8'b0, pif.pair_delta}, {8'b0, mq[0].delta});
    end
`ifdef SWEEP_PAIR_STATS_EN
    chk("orphan_count", {16'b0, orphan_count}, m_orphan);
    chk("drop_count", {16'b0, drop_count}, m_drop);
`endif
  endtask

  // Called at a negedge: drive, let the posedge happen, update the model, check at the next negedge.
  task automatic cyc(input bit p, input logic [DATA_W-1:0] w, input logic [TS_W-1:0] ts,
                     input logic [TS_W-1:0] st, input bit rdy);
    dav = p; ddata = w; dts = ts; sys = st; pif.pair_ready = rdy;
    @(posedge clk);
    model_step(p, w, ts, st, rdy);
    @(negedge clk);
    dav = 0;
    check_outputs();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {31'b0, pif.pair_valid}, 0);
    chk("rst_count", {29'b0, fifo_count}, 0);
    chk("rst_overflow", {31'b0, overflow}, 0);
    chk("rst_data_0", {15'b0, pif.pair_data_0}, 0);
    chk("rst_data_1", {15'b0, pif.pair_data_1}, 0);
    chk("rst_ts_0", {8'b0, pif.pair_ts_0}, 0);
    chk("rst_delta", {8'b0, pif.pair_delta}, 0);
    reset = 1'b0;
  endtask

  logic [TS_W-1:0] now;
  logic [TS_W-1:0] step;
  int              sel;

  initial begin
    pif.pair_ready = 1'b0;
    @(negedge clk);
    do_reset();

    // Basic pair, latency one cycle.
    cyc(1, 17'h0ABCD, 24'd1000, 24'd1000, 0);
    cyc(1, 17'h1F00F, 24'd5000, 24'd5000, 0);
    chk("t1_valid", {31'b0, pif.pair_valid}, 1);
    chk("t1_data_0", {15'b0, pif.pair_data_0}, 32'h0ABCD);
    chk("t1_data_1", {15'b0, pif.pair_data_1}, 32'h1F00F);
    chk("t1_ts_0", {8'b0, pif.pair_ts_0}, 1000);
    chk("t1_delta", {8'b0, pif.pair_delta}, 4000);
    cyc(0, '0, '0, 24'd5001, 1);

    // Timestamp wrap.
    cyc(1, 17'h00011, 24'hFFFF00, 24'hFFFF00, 0);
    cyc(1, 17'h00022, 24'h000100, 24'h000100, 0);
    chk("wrap_delta", {8'b0, pif.pair_delta}, 32'h200);
    cyc(0, '0, '0, 24'h000101, 1);

    // Timeout: the word at ts 960000 would have paired with ts 0 had the FSM not gone idle.
    do_reset();
    cyc(1, 17'h00100, 24'd0, 24'd0, 0);
    cyc(0, '0, '0, 24'd960000, 0);
    cyc(0, '0, '0, 24'd960001, 0);
    cyc(1, 17'h00200, 24'd960000, 24'd960002, 0);
    chk("timeout_count", {29'b0, fifo_count}, 0);
    cyc(1, 17'h00300, 24'd960100, 24'd960100, 0);
    chk("timeout_data_0", {15'b0, pif.pair_data_0}, 32'h00200);
    cyc(0, '0, '0, 24'd960101, 1);

    // Gap just over the limit replaces the first word.
    cyc(1, 17'h00401, 24'd100, 24'd100, 0);
    cyc(1, 17'h00402, 24'd960101, 24'd960101, 0);
    chk("gap_count", {29'b0, fifo_count}, 0);
    cyc(1, 17'h00403, 24'd960201, 24'd960201, 0);
    chk("gap_data_0", {15'b0, pif.pair_data_0}, 32'h00402);
    chk("gap_delta", {8'b0, pif.pair_delta}, 100);
    cyc(0, '0, '0, 24'd960202, 1);

    // Overflow: five pairs into depth four, then drain in order.
    do_reset();
    now = 24'd10;
    for (int i = 0; i < 10; i++) begin
      cyc(1, 17'(i + 1), now, now, 0);
      now += 24'd10;
    end
    chk("ovf_count", {29'b0, fifo_count}, 4);
    chk("ovf_flag", {31'b0, overflow}, 1);
    for (int i = 0; i < 5; i++) cyc(0, '0, '0, now, 1);

    // Full with simultaneous push and pop.
    do_reset();
    now = 24'd10;
    for (int i = 0; i < 8; i++) begin
      cyc(1, 17'(i + 32), now, now, 0);
      now += 24'd1;
    end
    cyc(1, 17'h1AAAA, now, now, 0);
    cyc(1, 17'h1BBBB, now + 24'd1, now + 24'd1, 1);
    chk("pp_count", {29'b0, fifo_count}, 4);
    chk("pp_overflow", {31'b0, overflow}, 0);

    // Reset with a half-built pair.
    cyc(1, 17'h15555, now + 24'd5, now + 24'd5, 0);
    do_reset();
    cyc(1, 17'h12345, 24'd50, 24'd50, 0);
    chk("post_rst_count", {29'b0, fifo_count}, 0);

    // Randomized traffic with timestamps around the gap boundary.
    now = 24'd100;
    for (int i = 0; i < 1500; i++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0:       step = 24'd0;
        1, 2, 3: step = 24'($urandom_range(1, 40));
        4:       step = 24'($urandom_range(959990, 960010));
        default: step = 24'($urandom_range(0, 3));
      endcase
      now += step;
      cyc(($urandom_range(0, 2) == 0), 17'($urandom), now, now, ($urandom_range(0, 3) != 0) ^ (i[8]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
